// File: rtl/seq_div16_if.sv
// Handshake and operand/result bundle for the sequential divider.
interface seq_div16_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_div16.sv
// Multi-cycle restoring divider: one quotient bit per clock, MSB first.
// A zero divisor skips the iteration and reports all-ones / dividend.
module seq_div16 #(
  parameter int unsigned WIDTH = 16
) (
  input logic        clk,
  input logic        rst_n,
  seq_div16_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] acc;        // dividend bits shift out the top, quotient bits shift in the bottom
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic             dbz_q;

  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] acc_step;

  // One shift-subtract step; trial is one bit wider so a divisor with its MSB set still compares correctly
  always_comb begin
    trial    = {rem, acc[WIDTH-1]};
    fits     = (trial >= {1'b0, dsr});
    rem_step = fits ? WIDTH'(trial - {1'b0, dsr}) : trial[WIDTH-1:0];
    acc_step = {acc[WIDTH-2:0], fits};
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.start) state_next = (bus.divisor == '0) ? DONE : CALC;
      CALC: if (cnt == CW'(1)) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc   <= '0;
      dsr   <= '0;
      rem   <= '0;
      cnt   <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc   <= bus.dividend;
            dsr   <= bus.divisor;
            rem   <= '0;
            dbz_q <= (bus.divisor == '0);
            if (bus.divisor == '0) begin
              cnt   <= '0;
              quo_q <= '1;
              rem_q <= bus.dividend;
            end else begin
              cnt   <= CW'(WIDTH);
            end
          end
        end
        CALC: begin
          acc <= acc_step;
          rem <= rem_step;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            quo_q <= acc_step;
            rem_q <= rem_step;
          end
        end
        default: ;
      endcase
    end
  end

  // Status decoded from state; results straight from their registers
  always_comb begin
    bus.busy        = (state != IDLE);
    bus.done        = (state == DONE);
    bus.quotient    = quo_q;
    bus.remainder   = rem_q;
    bus.div_by_zero = dbz_q;
  end
endmodule

// File: tb/tb_seq_div16.sv
// Directed bench for seq_div16 with hand-computed expected results.
module tb_seq_div16;
  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  seq_div16_if #(.WIDTH(16)) bus ();

  seq_div16 #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are observed on the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // lat = index of the edge after acceptance that samples done high; -1 on timeout
  task automatic wait_done(input int first, output int lat);
    bit found;
    found = 1'b0;
    lat   = first;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) begin
        found = 1'b1;
        break;
      end
      tick();
      lat++;
    end
    if (!found) lat = -1;
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input int exp_lat, input logic [15:0] eq, input logic [15:0] er,
                        input logic ez);
    int lat;
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    wait_done(1, lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_q"}, 32'(bus.quotient), 32'(eq));
    chk({tag, "_r"}, 32'(bus.remainder), 32'(er));
    chk({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(ez));
    tick();
    chk({tag, "_done_1cyc"}, 32'(bus.done), 32'd0);
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int lat;
    rst_n        = 1'b0;
    bus.start    = 1'b1;
    bus.dividend = 16'd100;
    bus.divisor  = 16'd7;
    @(negedge clk);

    // Reset held two edges with start high
    tick();
    tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_q", 32'(bus.quotient), 32'd0);
    chk("rst_r", 32'(bus.remainder), 32'd0);
    chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    bus.start = 1'b0;
    rst_n     = 1'b1;

    // Basic and extreme operands
    run_op("basic",  16'd100,  16'd7,    17, 16'd14,   16'd2,    1'b0);
    repeat (3) tick();
    chk("hold_q", 32'(bus.quotient), 32'd14);
    chk("hold_r", 32'(bus.remainder), 32'd2);
    run_op("ffff_1", 16'hFFFF, 16'h0001, 17, 16'hFFFF, 16'h0000, 1'b0);
    run_op("ffff_8k", 16'hFFFF, 16'h8000, 17, 16'h0001, 16'h7FFF, 1'b0);
    run_op("ffff_8k1", 16'hFFFF, 16'h8001, 17, 16'h0001, 16'h7FFE, 1'b0);
    run_op("3_10",   16'd3,    16'd10,   17, 16'd0,    16'd3,    1'b0);
    run_op("0_5",    16'd0,    16'd5,    17, 16'd0,    16'd0,    1'b0);

    // Divide by zero, then a normal operation clears the flag
    run_op("dbz",    16'd5,    16'd0,    1,  16'hFFFF, 16'd5,    1'b1);
    run_op("after_dbz", 16'd9, 16'd3,    17, 16'd3,    16'd0,    1'b0);

    // start and operand changes during CALC are ignored
    bus.dividend = 16'd100;
    bus.divisor  = 16'd7;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
    repeat (4) tick();
    bus.dividend = 16'd50;
    bus.divisor  = 16'd5;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
    chk("ign_q_hold", 32'(bus.quotient), 32'd3);
    wait_done(6, lat);
    chk("ign_lat", 32'(lat), 32'd17);
    chk("ign_q", 32'(bus.quotient), 32'd14);
    chk("ign_r", 32'(bus.remainder), 32'd2);
    tick();
    chk("ign_done_1cyc", 32'(bus.done), 32'd0);
    tick();
    chk("ign_no_queue", 32'(bus.busy), 32'd0);

    // Reset in the middle of an operation
    bus.dividend = 16'd1000;
    bus.divisor  = 16'd3;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_q", 32'(bus.quotient), 32'd0);
    chk("mid_rst_r", 32'(bus.remainder), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("mid_rst_nodone", 32'(bus.done), 32'd0);
    run_op("after_rst", 16'd1000, 16'd3, 17, 16'd333, 16'd1, 1'b0);

    // start held high relaunches on the first IDLE cycle after DONE
    bus.dividend = 16'd20;
    bus.divisor  = 16'd4;
    bus.start    = 1'b1;
    tick();
    bus.dividend = 16'd21;
    wait_done(1, lat);
    chk("held_lat1", 32'(lat), 32'd17);
    chk("held_q1", 32'(bus.quotient), 32'd5);
    chk("held_r1", 32'(bus.remainder), 32'd0);
    tick();
    chk("held_idle_done", 32'(bus.done), 32'd0);
    chk("held_idle_busy", 32'(bus.busy), 32'd0);
    tick();
    bus.start = 1'b0;
    chk("held_relaunch", 32'(bus.busy), 32'd1);
    wait_done(1, lat);
    chk("held_lat2", 32'(lat), 32'd17);
    chk("held_q2", 32'(bus.quotient), 32'd5);
    chk("held_r2", 32'(bus.remainder), 32'd1);
    tick();
    chk("held_done_1cyc", 32'(bus.done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
